// File: rtl/mips_control_pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Packages : Data_Control_Control
//            Mips_Control_Type_Signal_Pc_Signal_Action
//            Mips_Control_Type_Signal_Pc_Sequencer_State
// Purpose  : Shared types for the fetch-stage PC sequencer.
//            - clock/reset bundle carried on the ctrl port
//            - PC action code (None/Inc/Branch/Jump/JumpR)
//            - sequencer state encoding (BOOT/RUN/PEND, 2 bits)
// Revision : 1.0 - initial release
// ============================================================================
package Data_Control_Control;
  // Clock is sampled on its rising edge; Reset is asynchronous, active-low.
  typedef struct packed {
    logic Clock;
    logic Reset;
  } Data_Control_Control_T;
endpackage

package Mips_Control_Type_Signal_Pc_Signal_Action;
  typedef enum logic [2:0] {
    None   = 3'd0,
    Inc    = 3'd1,
    Branch = 3'd2,
    Jump   = 3'd3,
    JumpR  = 3'd4
  } Mips_Control_Type_Signal_Pc_Signal_Action_T;

  // Only these codes describe a real redirect.
  function automatic logic is_redirect(input Mips_Control_Type_Signal_Pc_Signal_Action_T k);
    return (k == Branch) || (k == Jump) || (k == JumpR);
  endfunction
endpackage

package Mips_Control_Type_Signal_Pc_Sequencer_State;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } Mips_Control_Type_Signal_Pc_Sequencer_State_T;
endpackage
`default_nettype wire

// File: rtl/mips_control_pc_sequencer_hold.sv
`default_nettype none
// ============================================================================
// Module   : mips_control_pc_sequencer_hold
// Purpose  : Capture register for a blocked redirect (kind + operands).
// Ports    : clk, rst_n (async active-low clear), i_load (capture enable),
//            i_kind/i_offset/i_jump/i_jumpr -> o_kind/o_offset/o_jump/o_jumpr
// Revision : 1.0 - initial release
// ============================================================================
module mips_control_pc_sequencer_hold
  import Mips_Control_Type_Signal_Pc_Signal_Action::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 16,
  parameter int JUMP_W   = 26
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_load,
  input  Mips_Control_Type_Signal_Pc_Signal_Action_T i_kind,
  input  logic [OFFSET_W-1:0]                        i_offset,
  input  logic [JUMP_W-1:0]                          i_jump,
  input  logic [ADDR_W-1:0]                          i_jumpr,
  output Mips_Control_Type_Signal_Pc_Signal_Action_T o_kind,
  output logic [OFFSET_W-1:0]                        o_offset,
  output logic [JUMP_W-1:0]                          o_jump,
  output logic [ADDR_W-1:0]                          o_jumpr
);

  Mips_Control_Type_Signal_Pc_Signal_Action_T r_kind;
  logic [OFFSET_W-1:0]                        r_offset;
  logic [JUMP_W-1:0]                          r_jump;
  logic [ADDR_W-1:0]                          r_jumpr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind   <= None;
      r_offset <= '0;
      r_jump   <= '0;
      r_jumpr  <= '0;
    end else if (i_load) begin
      r_kind   <= i_kind;
      r_offset <= i_offset;
      r_jump   <= i_jump;
      r_jumpr  <= i_jumpr;
    end
  end

  assign o_kind   = r_kind;
  assign o_offset = r_offset;
  assign o_jump   = r_jump;
  assign o_jumpr  = r_jumpr;

endmodule
`default_nettype wire

// File: rtl/mips_control_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_control_pc_sequencer
// Purpose  : Per-cycle fetch PC sequencer. Chooses the PC action, drives the
//            redirect operands, and holds a redirect that cannot issue
//            (stall or memory not ready) until the pipeline advances.
// Ports    : ctrl (Clock/Reset), imemReady, stall, reqValid, reqKind,
//            reqOffset, reqJump, reqJumpr -> action, offset, jump, jumpr,
//            fetchValid, flush, reqDrop, stallCount
// Revision : 1.0 - initial release
// ============================================================================
module mips_control_pc_sequencer
  import Data_Control_Control::*;
  import Mips_Control_Type_Signal_Pc_Signal_Action::*;
  import Mips_Control_Type_Signal_Pc_Sequencer_State::*;
#(
  parameter int ADDR_W     = 32,
  parameter int OFFSET_W   = 16,
  parameter int JUMP_W     = 26,
  parameter int DELAY_SLOT = 1,
  parameter int COUNT_W    = 16
) (
  input  Data_Control_Control_T                      ctrl,
  input  logic                                       imemReady,
  input  logic                                       stall,
  input  logic                                       reqValid,
  input  Mips_Control_Type_Signal_Pc_Signal_Action_T reqKind,
  input  logic [OFFSET_W-1:0]                        reqOffset,
  input  logic [JUMP_W-1:0]                          reqJump,
  input  logic [ADDR_W-1:0]                          reqJumpr,
  output Mips_Control_Type_Signal_Pc_Signal_Action_T action,
  output logic [OFFSET_W-1:0]                        offset,
  output logic [JUMP_W-1:0]                          jump,
  output logic [ADDR_W-1:0]                          jumpr,
  output logic                                       fetchValid,
  output logic                                       flush,
  output logic                                       reqDrop,
  output logic [COUNT_W-1:0]                         stallCount
);

  localparam logic c_FLUSH = (DELAY_SLOT == 0);

  logic w_clk;
  logic w_rst_n;
  assign w_clk   = ctrl.Clock;
  assign w_rst_n = ctrl.Reset;

  Mips_Control_Type_Signal_Pc_Sequencer_State_T r_state;
  Mips_Control_Type_Signal_Pc_Sequencer_State_T w_state_nxt;

  logic                                       w_advance;
  logic                                       w_req;
  logic                                       w_load;
  logic                                       w_redir;
  logic                                       w_use_hold;
  Mips_Control_Type_Signal_Pc_Signal_Action_T w_hold_kind;
  logic [OFFSET_W-1:0]                        w_hold_offset;
  logic [JUMP_W-1:0]                          w_hold_jump;
  logic [ADDR_W-1:0]                          w_hold_jumpr;
  logic [COUNT_W-1:0]                         r_stall_cnt;

  assign w_advance = imemReady & ~stall;
  // A request carrying None/Inc is not a redirect and is ignored entirely.
  assign w_req     = reqValid & is_redirect(reqKind);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= BOOT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    action      = None;
    fetchValid  = 1'b0;
    w_redir     = 1'b0;
    reqDrop     = 1'b0;
    w_load      = 1'b0;
    w_use_hold  = 1'b1;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        fetchValid = 1'b1;
        w_use_hold = 1'b0;
        if (w_req) begin
          if (w_advance) begin
            action  = reqKind;
            w_redir = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = PEND;
          end
        end else if (w_advance) begin
          action = Inc;
        end
      end
      PEND: begin
        fetchValid = 1'b1;
        // Only one redirect can be outstanding; a second one is lost.
        reqDrop    = w_req;
        if (w_advance) begin
          action      = w_hold_kind;
          w_redir     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign flush = w_redir & c_FLUSH;

  mips_control_pc_sequencer_hold #(
    .ADDR_W   (ADDR_W),
    .OFFSET_W (OFFSET_W),
    .JUMP_W   (JUMP_W)
  ) u_hold (
    .clk      (w_clk),
    .rst_n    (w_rst_n),
    .i_load   (w_load),
    .i_kind   (reqKind),
    .i_offset (reqOffset),
    .i_jump   (reqJump),
    .i_jumpr  (reqJumpr),
    .o_kind   (w_hold_kind),
    .o_offset (w_hold_offset),
    .o_jump   (w_hold_jump),
    .o_jumpr  (w_hold_jumpr)
  );

  // RUN passes decode operands straight through; BOOT/PEND show the capture
  // register, which is all-zero while reset is held.
  assign offset = w_use_hold ? w_hold_offset : reqOffset;
  assign jump   = w_use_hold ? w_hold_jump   : reqJump;
  assign jumpr  = w_use_hold ? w_hold_jumpr  : reqJumpr;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN || r_state == PEND) && !w_advance &&
                 (r_stall_cnt != {COUNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/mips_control_pc_sequencer.md
Name: mips_control_pc_sequencer

Overview:
- Per-cycle sequencer for the fetch-stage program counter.
- Each cycle it decides the PC action code (None/Inc/Branch/Jump/JumpR) and drives the matching redirect operands.
- Arbitrates redirect requests from decode against instruction-memory backpressure and hazard stalls.
- A redirect blocked by a stall or a not-ready memory is held internally and replayed when the pipeline can advance; a wrong-path flush is issued with it.

Parameters:
ADDR_W, 32, address width of jumpr operand
OFFSET_W, 16, branch offset width
JUMP_W, 26, jump target field width
DELAY_SLOT, 1, 1 = MIPS delay-slot semantics (no flush on redirect); 0 = flush fetched wrong-path instruction
COUNT_W, 16, width of saturating stall-cycle counter

Ports:
ctrl  input  Data_Control_Control_T  one clock (Clock field, rising edge); reset (Reset field) is asynchronous, active-low
imemReady  input  1  instruction memory accepts a fetch this cycle
stall  input  1  hazard unit: hold fetch/decode this cycle
reqValid  input  1  decode requests a redirect (taken branch, J/JAL, JR/JALR)
reqKind  input  Mips_Control_Type_Signal_Pc_Signal_Action_T  must be Branch, Jump or JumpR when reqValid=1
reqOffset  input  OFFSET_W  branch offset (words, signed)
reqJump  input  JUMP_W  jump target field
reqJumpr  input  ADDR_W  register jump target
action  output  Mips_Control_Type_Signal_Pc_Signal_Action_T  PC action this cycle
offset  output  OFFSET_W  to PC offset input
jump  output  JUMP_W  to PC jump input
jumpr  output  ADDR_W  to PC jumpr input
fetchValid  output  1  fetch address presented to memory is valid
flush  output  1  kill instruction in IF/ID register (DELAY_SLOT=0 only)
reqDrop  output  1  pulse: reqValid arrived while a redirect was already pending (protocol error)
stallCount  output  COUNT_W  saturating count of cycles with advance=0 in RUN/PEND

Behaviour:
- Definition: advance = imemReady & ~stall.
- Async reset (Reset low):
  - state=BOOT; captured kind/operands=0; stallCount=0.
  - Outputs while reset is low: action=None, fetchValid=0, flush=0, reqDrop=0, offset/jump/jumpr=0.
- BOOT:
  - Lasts exactly one cycle after reset release.
  - Outputs: action=None, fetchValid=0.
  - Next state: RUN unconditionally.
- RUN:
  - fetchValid=1; operand outputs bypass the req* inputs combinationally.
  - reqValid & advance: action=reqKind; flush=~DELAY_SLOT; stay in RUN.
  - reqValid & ~advance: action=None; capture reqKind/operands at the edge; go to PEND.
  - ~reqValid: action = advance ? Inc : None.
- PEND:
  - fetchValid=1; operand outputs come from the captured registers.
  - ~advance: action=None.
  - advance: action=captured kind; flush=~DELAY_SLOT; go to RUN.
  - reqValid in PEND: ignored; reqDrop=1 that cycle; captured values unchanged.
- Latency:
  - Unblocked redirect: 0 cycles (same-cycle action).
  - Blocked redirect: issues in the first cycle with advance=1.
- stallCount:
  - Increments each cycle in RUN/PEND with advance=0.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Reset asserted mid-PEND discards the pending redirect with no replay.
- flush is never asserted with action None or Inc.
- Invalid reqKind (None/Inc) with reqValid=1 is treated as no request (action per ~reqValid rule).

Decomposition:
- Action encoding and type come from the existing Mips_Control_Type_Signal_Pc_Signal_Action package.
- Add sequencer state encoding (BOOT/RUN/PEND, 2 bits) as a new shared package: Mips_Control_Type_Signal_Pc_Sequencer_State.
- One natural sub-module: mips_control_pc_sequencer_hold, the capture register for kind plus offset/jump/jumpr, with load enable and async active-low clear.
- Counter stays inline.

Test Plan:
- Reset release, imemReady=1, stall=0, no requests -> BOOT cycle (action=None, fetchValid=0), then action=Inc every cycle; stallCount=0.
- RUN, reqValid=1, reqKind=Branch, reqOffset=16'hFFFE, advance=1 -> same cycle: action=Branch, offset=16'hFFFE, flush=0 (DELAY_SLOT=1) / flush=1 (DELAY_SLOT=0).
- reqValid=1, Jump, reqJump=26'h0100040, stall=1 for 3 cycles, req inputs changed to garbage after cycle 1 -> action=None x3, jump held 26'h0100040; 4th cycle action=Jump; stallCount=3.
- PEND with JumpR 32'h00400020 plus new reqValid during the stall -> reqDrop=1 that cycle; replayed action=JumpR with jumpr=32'h00400020.
- Reset asserted while in PEND, then released -> BOOT then Inc; no replay of the pending redirect.
- COUNT_W=4, stall held 20 cycles -> stallCount reaches 4'hF and holds 4'hF.
